csa_bist: RTL and testbench
===========================

# csa_bist

Built-in self-test driver and checker for the 32-bit carry-select adder (`CSA_ADDER`). It sits on the opposite side of the adder's `A/B/Cin -> S/Cout` interface: it generates operand vectors, holds them for a configurable settle time, and samples the adder outputs. It compares each result against an internal golden sum and reports pass/fail statistics, so the adder is checked in silicon or emulation without a simulation testbench.

## Interface
- `WIDTH`, default 32: operand width; must match the adder under test.
- `NUM_VECTORS`, default 256: vectors per run; legal range 1..65535, and at least 5 when `CSA_BIST_DIRECTED_EN` is defined.
- `SETTLE_CYCLES`, default 2: cycles the operands are held before the result is sampled; minimum 1.
- `SEED`, default 32'hACE12345: LFSR seed; a value of 0 is replaced by 1.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: begins a run; sampled only in IDLE or DONE.
- `A`, output, WIDTH: operand to the adder (registered).
- `B`, output, WIDTH: operand to the adder (registered).
- `Cin`, output, 1: carry-in to the adder (registered).
- `S`, input, WIDTH: sum from the adder.
- `Cout`, input, 1: carry-out from the adder.
- `busy`, output, 1: high while a run is in progress.
- `done`, output, 1: high from run completion until the next start or reset.
- `pass`, output, 1: `done && fail_count == 0`.
- `vec_count`, output, 16: number of vectors checked.
- `fail_count`, output, 16: number of mismatches; saturates at 16'hFFFF.
- `first_fail_idx`, output, 16: index of the first mismatching vector; 16'hFFFF if there is none.

## Operation
- Reset values: `A=0`, `B=0`, `Cin=0`, `busy=0`, `done=0`, `pass=0`, `vec_count=0`, `fail_count=0`, `first_fail_idx=16'hFFFF`. The FSM goes to IDLE and the LFSR is loaded with `SEED`.
- **FSM states:** IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE + `start` -> APPLY. This transition clears the counters, sets `first_fail_idx=16'hFFFF`, reloads the LFSR and zeroes the vector index `idx`.
  - APPLY loads `A`, `B` and `Cin` for vector `idx`, then goes to SETTLE.
  - SETTLE counts `SETTLE_CYCLES` cycles, then goes to CHECK.
  - CHECK compares `{Cout,S}` against the golden value `A + B + Cin`, evaluated at WIDTH+1 bits unsigned.
    - On a mismatch, `fail_count` increments (saturating). If this is the first failure, `first_fail_idx` is set to `idx`.
    - `vec_count` increments on every CHECK.
    - If `idx == NUM_VECTORS-1` the FSM goes to DONE; otherwise `idx` increments and the FSM goes to APPLY.
  - DONE + `start` -> APPLY, with the same clearing as from IDLE.
  - `busy` is high in APPLY, SETTLE and CHECK.
- **Vector generation** uses a 32-bit Galois LFSR: `next(x) = (x>>1) ^ (x[0] ? 32'h80200003 : 0)`. In APPLY for a random vector, with current state `L`:
  - `A = L`
  - `B = next(L)`
  - `Cin = next(L)[0]`
  - The LFSR advances to `next(next(L))`.
- `start` during `busy` is ignored.
- Reset asserted mid-run aborts the run. All outputs take their reset values on that edge, and no partial result is retained.

## Timing
- `start` is sampled at edge k. `A`, `B` and `Cin` for vector 0 are valid after edge k+1.
- Each vector takes `SETTLE_CYCLES + 2` cycles.
- `done` rises after edge `k + NUM_VECTORS*(SETTLE_CYCLES+2)`. `busy` falls on the same edge.
- Counter updates from a CHECK are visible the cycle after that CHECK.
- `S` and `Cout` are sampled in CHECK only. The adder must settle within `SETTLE_CYCLES+1` clock periods.

## Configuration
- Macro: `CSA_BIST_DIRECTED_EN`.
- **Defined:** vectors 0-4 are fixed corner cases. The LFSR starts at vector 5 and is not stepped during vectors 0-4.
  - Vector 0: FFFFFFFF + 00000001, Cin 0 -> S=00000000, Cout=1.
  - Vector 1: 80000000 + FFFFFFFF, Cin 1 -> S=80000000, Cout=1.
  - Vector 2: 00000005 + FFFFFFFD, Cin 0 -> S=00000002, Cout=1.
  - Vector 3: 00000007 + 0000000A, Cin 0 -> S=00000011, Cout=0.
  - Vector 4: FFFFFFFC + FFFFFFF8, Cin 0 -> S=FFFFFFF4, Cout=1.
- **Undefined:** all vectors come from the LFSR, starting at vector 0.

## Test plan
- **Correct adder:** connect a correct `CSA_ADDER`, NUM_VECTORS=256, SETTLE_CYCLES=2, start pulse -> `done` rises exactly 1024 cycles after the start edge; `pass=1`, `vec_count=256`, `fail_count=0`, `first_fail_idx=FFFF`.
- **Directed vectors (macro defined):** probe `A`/`B`/`Cin` during vectors 0-4 -> they match the five listed vectors exactly; vector 5 has `A=ACE12345`.
- **Stuck-at-0 fault:** force `S[0]` stuck at 0 with the macro defined -> vector 0 passes (expected S=0); vector 3 (S=11) fails, so `first_fail_idx=3`; `fail_count` is greater than 0 and `pass=0`.
- **Start while busy:** pulse `start` again at cycle 10 of a run -> it is ignored; the run completion time and counters are unchanged.
- **Reset mid-run:** drive `rst_n` low at cycle 50 -> on the next edge all outputs are at their reset values; a fresh start afterwards reproduces the identical vector sequence.
- **Seed 0:** SEED=0, macro undefined -> the first vector is `A=00000001`, `B=80200003`, `Cin=1`.

Source files
------------

// File: rtl/csa_bist.sv
// ---------------------------------------------------------------------------
// csa_bist -- built-in self-test driver/checker for a carry-select adder.
//
// Drives operand vectors onto an external adder, holds each one for
// SETTLE_CYCLES, samples the adder result and compares it against an
// internal golden sum. Pass/fail statistics stay visible once the run is done.
//
// Optional feature macro: CSA_BIST_DIRECTED_EN
//   defined   : vectors 0-4 are fixed corner cases; the LFSR takes over at 5
//   undefined : every vector comes from the LFSR
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   start          in   begin a run (honoured only in IDLE or DONE)
//   A, B           out  WIDTH-bit registered operands to the adder
//   Cin            out  registered carry-in to the adder
//   S              in   WIDTH-bit sum from the adder
//   Cout           in   carry-out from the adder
//   busy           out  run in progress (APPLY/SETTLE/CHECK)
//   done           out  run complete, held until next start or reset
//   pass           out  done with zero mismatches
//   vec_count      out  vectors checked
//   fail_count     out  mismatches, saturating at 16'hFFFF
//   first_fail_idx out  index of the first mismatching vector, FFFF if none
// ---------------------------------------------------------------------------
module csa_bist #(
  parameter int          WIDTH         = 32,
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'hACE12345
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  input  logic [WIDTH-1:0] S,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      vec_count,
  output logic [15:0]      fail_count,
  output logic [15:0]      first_fail_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [31:0] LFSR_TAPS   = 32'h80200003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction

  state_t           r_state;
  logic [31:0]      r_lfsr;
  logic [15:0]      r_idx;
  logic [15:0]      r_settle_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_vec_count;
  logic [15:0]      r_fail_count;
  logic [15:0]      r_first_fail;

  logic [31:0]      w_l1;
  logic [31:0]      w_l2;
  logic [WIDTH:0]   w_golden;
  logic             w_mismatch;
  logic             w_last;

  assign w_l1       = lfsr_next(r_lfsr);
  assign w_l2       = lfsr_next(w_l1);
  assign w_golden   = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_mismatch = ({Cout, S} != w_golden);
  assign w_last     = (r_idx == LAST_IDX);

`ifdef CSA_BIST_DIRECTED_EN
  // Corner cases: full carry ripple, sign-bit overflow with Cin, borrow-like
  // wrap, no-carry small sum, and large negative + negative.
  logic [31:0] w_dir_a;
  logic [31:0] w_dir_b;
  logic        w_dir_cin;
  logic        w_dir_sel;

  assign w_dir_sel = (r_idx < 16'd5);

  always_comb begin
    w_dir_a   = 32'h0;
    w_dir_b   = 32'h0;
    w_dir_cin = 1'b0;
    case (r_idx[2:0])
      3'd0: begin w_dir_a = 32'hFFFFFFFF; w_dir_b = 32'h00000001; w_dir_cin = 1'b0; end
      3'd1: begin w_dir_a = 32'h80000000; w_dir_b = 32'hFFFFFFFF; w_dir_cin = 1'b1; end
      3'd2: begin w_dir_a = 32'h00000005; w_dir_b = 32'hFFFFFFFD; w_dir_cin = 1'b0; end
      3'd3: begin w_dir_a = 32'h00000007; w_dir_b = 32'h0000000A; w_dir_cin = 1'b0; end
      3'd4: begin w_dir_a = 32'hFFFFFFFC; w_dir_b = 32'hFFFFFFF8; w_dir_cin = 1'b0; end
      default: begin w_dir_a = 32'h0; w_dir_b = 32'h0; w_dir_cin = 1'b0; end
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= SEED_EFF;
      r_idx        <= 16'h0;
      r_settle_cnt <= 16'h0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_vec_count  <= 16'h0;
      r_fail_count <= 16'h0;
      r_first_fail <= 16'hFFFF;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_APPLY;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_vec_count  <= 16'h0;
            r_fail_count <= 16'h0;
            r_first_fail <= 16'hFFFF;
            r_lfsr       <= SEED_EFF;
            r_idx        <= 16'h0;
          end
        end

        ST_APPLY: begin
`ifdef CSA_BIST_DIRECTED_EN
          if (w_dir_sel) begin
            // LFSR holds still so that vector 5 sees SEED.
            r_a   <= WIDTH'(w_dir_a);
            r_b   <= WIDTH'(w_dir_b);
            r_cin <= w_dir_cin;
          end else
`endif
          begin
            r_a    <= WIDTH'(r_lfsr);
            r_b    <= WIDTH'(w_l1);
            r_cin  <= w_l1[0];
            r_lfsr <= w_l2;
          end
          r_settle_cnt <= 16'h0;
          r_state      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end

        ST_CHECK: begin
          r_vec_count <= r_vec_count + 16'd1;
          if (w_mismatch) begin
            if (r_fail_count != 16'hFFFF) begin
              r_fail_count <= r_fail_count + 16'd1;
            end
            // A zero count means no earlier failure in this run.
            if (r_fail_count == 16'h0) begin
              r_first_fail <= r_idx;
            end
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_mismatch && (r_fail_count == 16'h0);
          end else begin
            r_idx   <= r_idx + 16'd1;
            r_state <= ST_APPLY;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign A              = r_a;
  assign B              = r_b;
  assign Cin            = r_cin;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign vec_count      = r_vec_count;
  assign fail_count     = r_fail_count;
  assign first_fail_idx = r_first_fail;

endmodule

// File: tb/tb_csa_bist.sv
// ---------------------------------------------------------------------------
// tb_csa_bist -- directed bench for csa_bist.
//
// A behavioural adder closes the loop; fault_en forces its S[0] to 0. A
// second instance with SEED=0 and a short run covers the seed substitution.
// Expectations follow CSA_BIST_DIRECTED_EN when the bench is built with it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csa_bist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fault_en;

  logic [31:0] a, b, s;
  logic        cin, cout, busy, done, pass;
  logic [15:0] vc, fc, ffi;
  logic [32:0] sum;

  logic [31:0] a0, b0, s0;
  logic        cin0, cout0, busy0, done0, pass0;
  logic [15:0] vc0, fc0, ffi0;
  logic [32:0] sum0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sum  = {1'b0, a} + {1'b0, b} + {32'h0, cin};
  assign s    = fault_en ? {sum[31:1], 1'b0} : sum[31:0];
  assign cout = sum[32];

  assign sum0  = {1'b0, a0} + {1'b0, b0} + {32'h0, cin0};
  assign s0    = sum0[31:0];
  assign cout0 = sum0[32];

  csa_bist #(.WIDTH(32), .NUM_VECTORS(256), .SETTLE_CYCLES(2), .SEED(32'hACE12345)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vc), .fail_count(fc), .first_fail_idx(ffi)
  );

  csa_bist #(.WIDTH(32), .NUM_VECTORS(8), .SETTLE_CYCLES(2), .SEED(32'h0)) dut_seed0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(a0), .B(b0), .Cin(cin0), .S(s0), .Cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vc0), .fail_count(fc0), .first_fail_idx(ffi0)
  );

  // Hand-computed expected operands for the first vectors of a run.
`ifdef CSA_BIST_DIRECTED_EN
  localparam int NPROBE = 6;
  localparam logic [31:0] EXP_A [0:5] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000005,
                                          32'h00000007, 32'hFFFFFFFC, 32'hACE12345};
  localparam logic [31:0] EXP_B [0:5] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                          32'h0000000A, 32'hFFFFFFF8, 32'hD65091A1};
  localparam logic        EXP_C [0:5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] EXP_FFI     = 16'd3;
`else
  localparam int NPROBE = 2;
  localparam logic [31:0] EXP_A [0:1] = '{32'hACE12345, 32'hEB0848D3};
  localparam logic [31:0] EXP_B [0:1] = '{32'hD65091A1, 32'hF5A4246A};
  localparam logic        EXP_C [0:1] = '{1'b1, 1'b0};
  localparam logic [15:0] EXP_FFI     = 16'd0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_A"},    {32'h0, a},   64'h0);
    chk({tag, "_B"},    {32'h0, b},   64'h0);
    chk({tag, "_Cin"},  {63'h0, cin}, 64'h0);
    chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
    chk({tag, "_done"}, {63'h0, done}, 64'h0);
    chk({tag, "_pass"}, {63'h0, pass}, 64'h0);
    chk({tag, "_vc"},   {48'h0, vc},  64'h0);
    chk({tag, "_fc"},   {48'h0, fc},  64'h0);
    chk({tag, "_ffi"},  {48'h0, ffi}, 64'hFFFF);
  endtask

  // Pulse start, then count edges until done. Optionally re-pulse start at
  // run cycle pulse_at and probe operands of the first vectors.
  task automatic run(input int pulse_at, input bit probe, input int max_edges, output int cycles);
    int v;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    cycles = 0;
    while (cycles < max_edges) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == pulse_at);
      if (probe && ((cycles - 1) % 4 == 0) && ((cycles - 1) / 4 < NPROBE)) begin
        v = (cycles - 1) / 4;
        chk($sformatf("vec%0d_A", v),   {32'h0, a},   {32'h0, EXP_A[v]});
        chk($sformatf("vec%0d_B", v),   {32'h0, b},   {32'h0, EXP_B[v]});
        chk($sformatf("vec%0d_Cin", v), {63'h0, cin}, {63'h0, EXP_C[v]});
`ifdef CSA_BIST_DIRECTED_EN
        if (v == 5) chk("seed0_vec5_A", {32'h0, a0}, 64'h1);
`else
        if (v == 0) begin
          chk("seed0_A",   {32'h0, a0},   64'h1);
          chk("seed0_B",   {32'h0, b0},   64'h80200003);
          chk("seed0_Cin", {63'h0, cin0}, 64'h1);
        end
`endif
      end
      if (done) break;
    end
    start = 1'b0;
    if (!done) chk("run_timeout", {63'h0, done}, 64'h1);
  endtask

  initial begin
    int cyc;
    rst_n    = 1'b0;
    start    = 1'b0;
    fault_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;

    // Correct adder: full run, timing and statistics.
    run(0, 1'b1, 2000, cyc);
    chk("run1_cycles", 64'(cyc), 64'd1024);
    chk("run1_pass",  {63'h0, pass}, 64'h1);
    chk("run1_busy",  {63'h0, busy}, 64'h0);
    chk("run1_vc",    {48'h0, vc},   64'd256);
    chk("run1_fc",    {48'h0, fc},   64'd0);
    chk("run1_ffi",   {48'h0, ffi},  64'hFFFF);
    chk("seed0_done", {63'h0, done0}, 64'h1);
    chk("seed0_pass", {63'h0, pass0}, 64'h1);
    chk("seed0_vc",   {48'h0, vc0},  64'd8);

    // Start pulse mid-run is ignored.
    run(10, 1'b0, 2000, cyc);
    chk("run2_cycles", 64'(cyc), 64'd1024);
    chk("run2_pass", {63'h0, pass}, 64'h1);
    chk("run2_vc",   {48'h0, vc},   64'd256);
    chk("run2_fc",   {48'h0, fc},   64'd0);

    // S[0] stuck at 0.
    fault_en = 1'b1;
    run(0, 1'b0, 2000, cyc);
    fault_en = 1'b0;
    chk("fault_cycles", 64'(cyc), 64'd1024);
    chk("fault_ffi",    {48'h0, ffi}, {48'h0, EXP_FFI});
    chk("fault_fc_nz",  {63'h0, (fc != 16'h0)}, 64'h1);
    chk("fault_fc_le",  {63'h0, (fc <= 16'd256)}, 64'h1);
    chk("fault_pass",   {63'h0, pass}, 64'h0);
    chk("fault_done",   {63'h0, done}, 64'h1);
    chk("fault_vc",     {48'h0, vc},   64'd256);

    // Reset mid-run, then the fresh run must repeat the sequence.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("midrst");
    rst_n = 1'b1;
    run(0, 1'b1, 2000, cyc);
    chk("rerun_cycles", 64'(cyc), 64'd1024);
    chk("rerun_pass", {63'h0, pass}, 64'h1);
    chk("rerun_fc",   {48'h0, fc},   64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
